// File: rtl/sliding_window_frame_ctrl.sv
// ============================================================================
//  Module   : sliding_window_frame_ctrl
//  Purpose  : Frame sequencer that gates the pixel stream into the sliding-window
//             datapath one frame at a time and tags each emitted window.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sliding_window_frame_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMG_WIDTH       = 4,
    parameter int IMG_HEIGHT      = 4,
    parameter int CHANNELS        = 2,
    parameter int KERNEL_WIDTH    = 3,
    parameter int KERNEL_HEIGHT   = 3,
    parameter int PADDING_WIDTH   = 1,
    parameter int PADDING_HEIGHT  = 1,
    parameter int STRIDE          = 1,
    parameter int FRAME_CNT_WIDTH = 8,
    localparam int OUT_W = (IMG_WIDTH + 2*PADDING_WIDTH - KERNEL_WIDTH) / STRIDE + 1,
    localparam int OUT_H = (IMG_HEIGHT + 2*PADDING_HEIGHT - KERNEL_HEIGHT) / STRIDE + 1,
    localparam int OX_W  = $clog2(OUT_W) + 1,
    localparam int OY_W  = $clog2(OUT_H) + 1,
    localparam int C_W   = $clog2(CHANNELS) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [FRAME_CNT_WIDTH-1:0] num_frames,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       done,
    output logic                       err_overrun,
    input  logic                       src_valid,
    output logic                       src_ready,
    output logic                       dp_in_valid,
    input  logic                       dp_in_ready,
    input  logic                       dp_out_valid,
    input  logic                       dp_out_ready,
    output logic [OX_W-1:0]            out_ox,
    output logic [OY_W-1:0]            out_oy,
    output logic [C_W-1:0]             out_c
);

    localparam int IN_WORDS    = IMG_WIDTH * IMG_HEIGHT * CHANNELS;
    localparam int OUT_WINDOWS = OUT_W * OUT_H * CHANNELS;
    localparam int IN_CW       = $clog2(IN_WORDS + 1);
    localparam int OUT_CW      = $clog2(OUT_WINDOWS + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STREAM   = 2'd1,
        S_WAIT_OUT = 2'd2
    } state_t;

    state_t                     state_q;
    logic [IN_CW-1:0]           in_cnt_q;
    logic [OUT_CW-1:0]          out_cnt_q;
    logic [FRAME_CNT_WIDTH-1:0] frames_left_q;
    logic [OX_W-1:0]            ox_q, ox_d;
    logic [OY_W-1:0]            oy_q, oy_d;
    logic [C_W-1:0]             c_q, c_d;
    logic                       busy_q, frame_done_q, done_q, err_q;

    logic in_en, in_hs, out_hs, in_last, out_last;

    // Pixel words bypass this block, so their width is not needed here.
    logic unused_data_width;
    assign unused_data_width = (DATA_WIDTH != 0);

    assign in_en       = (state_q == S_STREAM);
    assign src_ready   = dp_in_ready && in_en;
    assign dp_in_valid = src_valid && in_en;

    always_comb begin
        in_hs    = dp_in_valid && dp_in_ready;
        out_hs   = dp_out_valid && dp_out_ready;
        in_last  = in_hs && (in_cnt_q == IN_CW'(IN_WORDS - 1));
        out_last = out_hs && (state_q != S_IDLE) && (out_cnt_q == OUT_CW'(OUT_WINDOWS - 1));
    end

    // Window order: channel fastest, then x, then y.
    always_comb begin
        c_d  = c_q + 1'b1;
        ox_d = ox_q;
        oy_d = oy_q;
        if (c_q == C_W'(CHANNELS - 1)) begin
            c_d  = '0;
            ox_d = ox_q + 1'b1;
            if (ox_q == OX_W'(OUT_W - 1)) begin
                ox_d = '0;
                oy_d = oy_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            frames_left_q <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            c_q           <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (out_hs) begin
                        err_q <= 1'b1;
                    end
                    if (start) begin
                        if (num_frames != '0) begin
                            frames_left_q <= num_frames;
                            state_q       <= S_STREAM;
                            busy_q        <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (in_hs) begin
                        in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_q <= S_WAIT_OUT;
                    end
                    if (out_last) begin
                        // Last window while input is still outstanding means the datapath ran ahead.
                        if (state_q == S_STREAM && !in_last) begin
                            err_q <= 1'b1;
                        end
                        in_cnt_q      <= '0;
                        out_cnt_q     <= '0;
                        ox_q          <= '0;
                        oy_q          <= '0;
                        c_q           <= '0;
                        frame_done_q  <= 1'b1;
                        frames_left_q <= frames_left_q - 1'b1;
                        if (frames_left_q == FRAME_CNT_WIDTH'(1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_STREAM;
                        end
                    end else if (out_hs) begin
                        out_cnt_q <= out_cnt_q + 1'b1;
                        ox_q      <= ox_d;
                        oy_q      <= oy_d;
                        c_q       <= c_d;
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign done        = done_q;
    assign err_overrun = err_q;
    assign out_ox      = ox_q;
    assign out_oy      = oy_q;
    assign out_c       = c_q;

endmodule

`default_nettype wire

// File: tb/tb_sliding_window_frame_ctrl.sv
// ============================================================================
//  Module   : tb_sliding_window_frame_ctrl
//  Purpose  : Self-checking bench for the sliding-window frame sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sliding_window_frame_ctrl;

    localparam int N_WORDS   = 32;
    localparam int N_WINDOWS = 32;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] num_frames;
    logic       busy, frame_done, done, err_overrun;
    logic       src_valid, src_ready, dp_in_valid, dp_in_ready;
    logic       dp_out_valid, dp_out_ready;
    logic [2:0] out_ox, out_oy;
    logic [1:0] out_c;

    sliding_window_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_frames   (num_frames),
        .busy         (busy),
        .frame_done   (frame_done),
        .done         (done),
        .err_overrun  (err_overrun),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .dp_in_valid  (dp_in_valid),
        .dp_in_ready  (dp_in_ready),
        .dp_out_valid (dp_out_valid),
        .dp_out_ready (dp_out_ready),
        .out_ox       (out_ox),
        .out_oy       (out_oy),
        .out_c        (out_c)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fd_cnt = 0;
    int done_cnt = 0;
    int exp_q[$];

    typedef struct {
        logic sv;
        logic ir;
        logic exp_sr;
        logic exp_div;
    } vec_t;
    vec_t tbl[4];

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int coord_now();
        return int'(out_oy) * 100 + int'(out_ox) * 10 + int'(out_c);
    endfunction

    task automatic apply_table(input bit streaming, input string tag);
        for (int i = 0; i < 4; i++) begin
            src_valid   = tbl[i].sv;
            dp_in_ready = tbl[i].ir;
            #1;
            check({tag, "_src_ready"},   src_ready,   streaming ? tbl[i].exp_sr  : 1'b0);
            check({tag, "_dp_in_valid"}, dp_in_valid, streaming ? tbl[i].exp_div : 1'b0);
        end
        src_valid   = 1'b0;
        dp_in_ready = 1'b0;
    endtask

    task automatic start_batch(input int n);
        start      = 1'b1;
        num_frames = 8'(n);
        step();
        start = 1'b0;
        check("busy_after_start", busy, (n != 0));
    endtask

    // One frame: inputs at in_pct%, downstream ready at out_pct%. Window k may be
    // emitted once word k is accepted (same cycle when coincide is set).
    task automatic run_frame(input int in_pct, input int out_pct, input bit coincide, input bit last);
        int  ins = 0;
        int  outs = 0;
        int  cyc = 0;
        bit  stall_bad = 1'b0;
        bit  in_hs, out_hs;
        for (int k = 0; k < N_WINDOWS; k++)
            exp_q.push_back((k / 8) * 100 + ((k / 2) % 4) * 10 + (k % 2));
        while (outs < N_WINDOWS && cyc < 3000) begin
            src_valid   = (ins < N_WORDS) && ($urandom_range(99) < in_pct);
            dp_in_ready = 1'b1;
            #1;
            in_hs = src_valid && src_ready;
            if (ins == N_WORDS && src_ready) stall_bad = 1'b1;
            dp_out_valid = (outs < ins + ((coincide && in_hs) ? 1 : 0));
            dp_out_ready = ($urandom_range(99) < out_pct);
            #1;
            out_hs = dp_out_valid && dp_out_ready;
            if (out_hs) begin
                if (exp_q.size() > 0) check("window_coord", coord_now(), exp_q.pop_front());
                else check("scoreboard_underflow", 1, 0);
            end
            if (in_hs) ins++;
            if (out_hs) outs++;
            cyc++;
            step();
        end
        src_valid    = 1'b0;
        dp_out_valid = 1'b0;
        dp_out_ready = 1'b0;
        check("windows_out", outs, N_WINDOWS);
        check("words_in", ins, N_WORDS);
        check("stall_in_wait_out", stall_bad, 0);
        check("frame_done_pulse", frame_done, 1);
        check("done_on_last", done, last);
        check("busy_after_frame", busy, !last);
        check("coord_cleared", coord_now(), 0);
        exp_q.delete();
    endtask

    initial begin
        int fd0, dn0;
        tbl[0] = '{sv: 1'b0, ir: 1'b0, exp_sr: 1'b0, exp_div: 1'b0};
        tbl[1] = '{sv: 1'b1, ir: 1'b0, exp_sr: 1'b0, exp_div: 1'b1};
        tbl[2] = '{sv: 1'b0, ir: 1'b1, exp_sr: 1'b1, exp_div: 1'b0};
        tbl[3] = '{sv: 1'b1, ir: 1'b1, exp_sr: 1'b1, exp_div: 1'b1};

        rst = 1'b1; start = 1'b0; num_frames = '0;
        src_valid = 1'b0; dp_in_ready = 1'b0; dp_out_valid = 1'b0; dp_out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        dp_in_ready = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_done", done, 0);
        check("rst_err", err_overrun, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_coord", coord_now(), 0);
        dp_in_ready = 1'b0;
        apply_table(1'b0, "idle");

        // Reset in the middle of a frame
        start_batch(2);
        apply_table(1'b1, "stream");
        src_valid = 1'b1; dp_in_ready = 1'b1; dp_out_valid = 1'b1; dp_out_ready = 1'b1;
        step(); step(); step();
        dp_out_valid = 1'b0;
        check("coord_mid_frame", coord_now(), 11);
        step(); step();
        src_valid = 1'b0;
        fd0 = fd_cnt; dn0 = done_cnt;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        dp_in_ready = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_src_ready", src_ready, 0);
        check("midrst_coord", coord_now(), 0);
        check("midrst_no_pulses", (fd_cnt - fd0) + (done_cnt - dn0), 0);
        dp_in_ready = 1'b0;
        step();

        // Single frame, continuous traffic
        fd0 = fd_cnt; dn0 = done_cnt;
        start_batch(1);
        run_frame(100, 100, 1'b0, 1'b1);
        step();
        check("single_fd_count", fd_cnt - fd0, 1);
        check("single_done_count", done_cnt - dn0, 1);
        check("single_busy_low", busy, 0);

        // Last window coincides with last input word
        start_batch(1);
        run_frame(100, 100, 1'b1, 1'b1);
        check("coincide_no_err", err_overrun, 0);
        step();

        // Three frames back to back
        fd0 = fd_cnt; dn0 = done_cnt;
        start_batch(3);
        run_frame(100, 100, 1'b0, 1'b0);
        run_frame(100, 100, 1'b0, 1'b0);
        run_frame(100, 100, 1'b0, 1'b1);
        step();
        check("b2b_fd_count", fd_cnt - fd0, 3);
        check("b2b_done_count", done_cnt - dn0, 1);

        // Backpressure on both sides
        start_batch(2);
        run_frame(50, 50, 1'b0, 1'b0);
        run_frame(50, 50, 1'b1, 1'b1);
        step();

        // Zero-frame command
        start_batch(0);
        check("zero_done", done, 1);
        step();
        check("zero_done_pulse", done, 0);
        check("zero_busy", busy, 0);

        // Start while busy must not reload the frame count
        start_batch(1);
        start = 1'b1; num_frames = 8'd5;
        step();
        start = 1'b0;
        run_frame(100, 100, 1'b0, 1'b1);
        check("ignored_start_err", err_overrun, 0);
        step();
        check("ignored_start_idle", busy, 0);

        // Window handshake while idle
        dp_out_valid = 1'b1; dp_out_ready = 1'b1;
        step();
        dp_out_valid = 1'b0; dp_out_ready = 1'b0;
        check("idle_err_set", err_overrun, 1);
        check("idle_err_no_count", coord_now(), 0);
        step(); step(); step();
        check("idle_err_sticky", err_overrun, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_cleared_by_rst", err_overrun, 0);

        // Datapath finishes the frame before all input is accepted
        start_batch(1);
        src_valid = 1'b1; dp_in_ready = 1'b1;
        step(); step();
        src_valid = 1'b0;
        dp_out_valid = 1'b1; dp_out_ready = 1'b1;
        for (int k = 0; k < N_WINDOWS; k++) step();
        dp_out_valid = 1'b0; dp_out_ready = 1'b0;
        check("overrun_err", err_overrun, 1);
        check("overrun_frame_done", frame_done, 1);
        check("overrun_done", done, 1);
        step();
        check("overrun_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
